neg_unit_arbiter: RTL and testbench
===================================

Name: neg_unit_arbiter

Overview:
- Shares one combinational 32-bit negation unit between NUM_REQ requesters in the eBPF core: ALU issue ports, the ALU32/ALU64 NEG path and the immediate pre-processor.
- Sequences BPF_NEG for both operand sizes:
  - ALU32: one pass, result zero-extended.
  - ALU64: two passes (low half, then high half with borrow correction).
- Round-robin arbitration; valid/ready handshake on the request and response sides.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of rsp_id; must be >= clog2(NUM_REQ).

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous reset, active-high
- req_valid  input  NUM_REQ  per-requester request valid
- req_ready  output  NUM_REQ  one-hot accept pulse to the granted requester
- req_operand  input  64*NUM_REQ  operand; requester i occupies bits [64*i+63:64*i]
- req_is64  input  NUM_REQ  1 = ALU64 negate, 0 = ALU32 negate
- neg_a  output  32  operand driven to the shared negation unit
- neg_c  input  32  result from the shared unit (combinational, same cycle as neg_a)
- rsp_valid  output  1  result valid
- rsp_ready  input  1  consumer accepts result
- rsp_id  output  ID_W  index of the requester that owns the result
- rsp_result  output  64  negated value
- op_count  output  32  completed-operation counter (see Optional Feature)

Behaviour:
- FSM states: IDLE, LO, HI, RESP. Reset values:
  - state = IDLE, rr_ptr = 0
  - req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_result = 0, neg_a = 0, op_count = 0
- IDLE:
  - Grant search starts at rr_ptr and wraps modulo NUM_REQ; the first set req_valid wins.
  - Same cycle: req_ready[g] = 1 for one cycle only. Latch operand, is64 and g. Go to LO.
  - No requester valid: stay in IDLE, all req_ready = 0.
- LO:
  - neg_a = op[31:0]; latch lo_res = neg_c and lo_nz = (op[31:0] != 0).
  - is64 = 1: go to HI.
  - is64 = 0: rsp_result = {32'h0, neg_c}; go to RESP. Operand bits [63:32] are ignored.
- HI:
  - neg_a = op[63:32].
  - rsp_result = {neg_c - lo_nz, lo_res}, i.e. two's-complement 64-bit negation, mod 2^64.
  - Go to RESP.
- RESP:
  - rsp_valid = 1; rsp_id and rsp_result held stable until rsp_ready.
  - On rsp_valid && rsp_ready: rsp_valid drops the next cycle, rr_ptr = (g + 1) mod NUM_REQ, go to IDLE.
- neg_a outside LO/HI holds its last value. The shared unit is treated as don't-care there.
- Latency (accept cycle T, rsp_ready held high):
  - ALU32: rsp_valid first high at T+2.
  - ALU64: rsp_valid first high at T+3.
  - Next grant no earlier than the cycle after the response handshake.
  - Throughput: one op per 3 cycles (ALU32), per 4 cycles (ALU64).
- Boundary conditions:
  - Requesters not granted see req_ready = 0 and must hold their request.
  - A request deasserted before grant is simply not granted; no error.
  - Operand 0: result 0 in both modes.
  - Operand 0x8000_0000_0000_0000 (ALU64): result 0x8000_0000_0000_0000.
  - Operand 0x8000_0000 (ALU32): result 0x0000_0000_8000_0000.
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - rst asserted in any state: next cycle is IDLE with reset values. An in-flight op is dropped, no rsp_valid is produced, and rr_ptr returns to 0.
  - rst has priority over a simultaneous handshake.

Optional Feature:
- Macro: NEG_ARB_STATS_EN.
- Defined: op_count increments by 1 on each response handshake (rsp_valid && rsp_ready), wraps at 2^32, and is cleared by rst.
- Undefined: op_count is tied to 32'h0 and no counter logic is synthesized.

Test Plan:
- Req 0, is64=0, operand 0xDEAD_BEEF_0000_0005, rsp_ready=1 -> req_ready[0] pulse at T; rsp_valid at T+2 with rsp_result 0x0000_0000_FFFF_FFFB, rsp_id 0.
- Req 1, is64=1, operand 0x0000_0000_0000_0001 -> rsp_result 0xFFFF_FFFF_FFFF_FFFF at T+3, rsp_id 1. Then operand 0x0000_0001_0000_0000 -> rsp_result 0xFFFF_FFFF_0000_0000.
- All 4 req_valid held high with distinct operands -> grant order 0,1,2,3,0. Exactly one req_ready bit per grant; results match the issuing requester's operand.
- rsp_ready held low 5 cycles during RESP -> rsp_valid, rsp_id and rsp_result stable throughout; no new req_ready until the handshake completes.
- rst pulsed while in HI for an ALU64 op -> no rsp_valid; outputs at reset values; the next request from requester 2 is granted with rr_ptr restarting at 0.
- NEG_ARB_STATS_EN defined, 6 completed ops -> op_count = 6; rst -> 0. Macro undefined -> op_count = 0 throughout.

Source files
------------

// File: rtl/neg_unit_arbiter.sv
// Round-robin arbiter sharing one 32-bit negation unit for ALU32/ALU64 NEG.
// Optional op counter enabled by defining NEG_ARB_STATS_EN.
module neg_unit_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [64*NUM_REQ-1:0] req_operand,
  input  logic [NUM_REQ-1:0]   req_is64,
  output logic [31:0]          neg_a,
  input  logic [31:0]          neg_c,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [63:0]          rsp_result,
  output logic [31:0]          op_count
);

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    RESP
  } state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] cur_id;
  logic [ID_W-1:0] nxt_ptr;
  logic [63:0]     op;
  logic            is64_q;
  logic            lo_nz;
  logic [31:0]     lo_res;

  logic            gnt_found;
  logic [ID_W-1:0] gnt_id;
  logic [63:0]     gnt_operand;
  logic            gnt_is64;

  // Rotating priority search starting at rr_ptr; first valid wins.
  always_comb begin
    int idx;
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = ID_W'(idx);
      end
    end
  end

  // Select the winning requester's operand and size.
  always_comb begin
    gnt_operand = '0;
    gnt_is64    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (ID_W'(k) == gnt_id) begin
        gnt_operand = req_operand[64*k +: 64];
        gnt_is64    = req_is64[k];
      end
    end
  end

  // One-hot accept pulse, only while idle and not being reset.
  always_comb begin
    req_ready = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (state == IDLE && gnt_found && !rst && ID_W'(k) == gnt_id)
        req_ready[k] = 1'b1;
    end
  end

  assign nxt_ptr = (cur_id == ID_W'(NUM_REQ - 1)) ? '0 : cur_id + 1'b1;

  // Main sequencer: grant, low pass, optional high pass, response hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      cur_id     <= '0;
      op         <= '0;
      is64_q     <= 1'b0;
      lo_nz      <= 1'b0;
      lo_res     <= '0;
      neg_a      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt_found) begin
            op     <= gnt_operand;
            is64_q <= gnt_is64;
            cur_id <= gnt_id;
            neg_a  <= gnt_operand[31:0];
            state  <= LO;
          end
        end
        LO: begin
          lo_res <= neg_c;
          lo_nz  <= |op[31:0];
          if (is64_q) begin
            neg_a <= op[63:32];
            state <= HI;
          end else begin
            rsp_result <= {32'h0, neg_c};
            rsp_id     <= cur_id;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end
        end
        HI: begin
          // Borrow from the low half whenever it was non-zero.
          rsp_result <= {neg_c - {31'h0, lo_nz}, lo_res};
          rsp_id     <= cur_id;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= nxt_ptr;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef NEG_ARB_STATS_EN
  logic [31:0] op_cnt_q;

  // Count completed response handshakes.
  always_ff @(posedge clk) begin
    if (rst)
      op_cnt_q <= '0;
    else if (rsp_valid && rsp_ready)
      op_cnt_q <= op_cnt_q + 32'd1;
  end

  assign op_count = op_cnt_q;
`else
  assign op_count = 32'h0;
`endif

endmodule

// File: tb/tb_neg_unit_arbiter.sv
// Directed bench for neg_unit_arbiter.
// Shared negation unit modelled as a plain 32-bit two's-complement negate.
module tb_neg_unit_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [255:0] req_operand = '0;
  logic [3:0]   req_is64 = '0;
  logic [31:0]  neg_a;
  logic [31:0]  neg_c;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [1:0]   rsp_id;
  logic [63:0]  rsp_result;
  logic [31:0]  op_count;

  int checks = 0;
  int errors = 0;
  int exp_ops = 0;

  logic [63:0] rr_op  [4];
  logic [63:0] rr_res [4];
  logic        rr_w   [4];
  int          rr_ord [5];

  neg_unit_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_operand(req_operand),
    .req_is64   (req_is64),
    .neg_a      (neg_a),
    .neg_c      (neg_c),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .op_count   (op_count)
  );

  assign neg_c = ~neg_a + 32'd1;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] exp_count;
`ifdef NEG_ARB_STATS_EN
    return 64'(exp_ops);
`else
    return 64'h0;
`endif
  endfunction

  task automatic reset_dut;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_ops = 0;
  endtask

  task automatic set_req(input int i, input logic [63:0] o, input logic w);
    req_operand[64*i +: 64] = o;
    req_is64[i]  = w;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_grant(input logic [3:0] exp);
    int n = 0;
    #1;
    while (req_ready == 4'b0 && n < 20) begin
      tick();
      n++;
    end
    check("grant", 64'(req_ready), 64'(exp));
    tick();
  endtask

  task automatic wait_rsp(input int lat_exp, input logic [1:0] id,
                          input logic [63:0] res);
    int lat = 1;
    while (!rsp_valid && lat < 10) begin
      tick();
      lat++;
    end
    check("latency", 64'(lat), 64'(lat_exp));
    check("rsp_id", 64'(rsp_id), 64'(id));
    check("result", rsp_result, res);
    if (rsp_ready) begin
      tick();
      exp_ops++;
      check("rsp_drop", 64'(rsp_valid), 64'h0);
    end
  endtask

  task automatic run_op(input int i, input logic [63:0] o, input logic w,
                        input logic [63:0] res);
    set_req(i, o, w);
    wait_grant(4'(1 << i));
    req_valid[i] = 1'b0;
    wait_rsp(w ? 3 : 2, 2'(i), res);
  endtask

  initial begin
    rr_op[0] = 64'h0000_0000_0000_0010; rr_w[0] = 1'b1;
    rr_res[0] = 64'hFFFF_FFFF_FFFF_FFF0;
    rr_op[1] = 64'hFFFF_FFFF_0000_0100; rr_w[1] = 1'b0;
    rr_res[1] = 64'h0000_0000_FFFF_FF00;
    rr_op[2] = 64'h0000_0002_0000_0000; rr_w[2] = 1'b1;
    rr_res[2] = 64'hFFFF_FFFE_0000_0000;
    rr_op[3] = 64'h0000_0000_7FFF_FFFF; rr_w[3] = 1'b0;
    rr_res[3] = 64'h0000_0000_8000_0001;
    rr_ord[0] = 0; rr_ord[1] = 1; rr_ord[2] = 2;
    rr_ord[3] = 3; rr_ord[4] = 0;

    reset_dut();
    check("rst_req_ready", 64'(req_ready), 64'h0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    check("rst_rsp_id", 64'(rsp_id), 64'h0);
    check("rst_rsp_result", rsp_result, 64'h0);
    check("rst_neg_a", 64'(neg_a), 64'h0);
    check("rst_op_count", 64'(op_count), 64'h0);

    run_op(0, 64'hDEAD_BEEF_0000_0005, 1'b0, 64'h0000_0000_FFFF_FFFB);
    run_op(1, 64'h0000_0000_0000_0001, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(1, 64'h0000_0001_0000_0000, 1'b1, 64'hFFFF_FFFF_0000_0000);
    run_op(2, 64'h0000_0000_0000_0000, 1'b1, 64'h0);
    run_op(3, 64'h1234_5678_8000_0000, 1'b0, 64'h0000_0000_8000_0000);
    run_op(0, 64'h8000_0000_0000_0000, 1'b1, 64'h8000_0000_0000_0000);

    // All four contending from a fresh pointer.
    reset_dut();
    for (int i = 0; i < 4; i++) set_req(i, rr_op[i], rr_w[i]);
    for (int k = 0; k < 5; k++) begin
      wait_grant(4'(1 << rr_ord[k]));
      wait_rsp(rr_w[rr_ord[k]] ? 3 : 2, 2'(rr_ord[k]), rr_res[rr_ord[k]]);
    end
    req_valid = '0;

    // Response back-pressure with another requester waiting.
    set_req(0, 64'h0000_0000_0000_0005, 1'b0);
    wait_grant(4'b0001);
    req_valid[0] = 1'b0;
    set_req(2, 64'h0000_0003_0000_0000, 1'b1);
    rsp_ready = 1'b0;
    wait_rsp(2, 2'd0, 64'h0000_0000_FFFF_FFFB);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_valid", 64'(rsp_valid), 64'h1);
      check("stall_id", 64'(rsp_id), 64'h0);
      check("stall_result", rsp_result, 64'h0000_0000_FFFF_FFFB);
      check("stall_ready", 64'(req_ready), 64'h0);
    end
    rsp_ready = 1'b1;
    tick();
    exp_ops++;
    check("stall_drop", 64'(rsp_valid), 64'h0);
    check("op_count6", 64'(op_count), exp_count());
    wait_grant(4'b0100);
    req_valid[2] = 1'b0;
    wait_rsp(3, 2'd2, 64'hFFFF_FFFD_0000_0000);

    // Reset while the high half is in flight.
    set_req(1, 64'h0000_0005_0000_0007, 1'b1);
    wait_grant(4'b0010);
    req_valid[1] = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_ops = 0;
    check("hrst_valid", 64'(rsp_valid), 64'h0);
    check("hrst_result", rsp_result, 64'h0);
    check("hrst_id", 64'(rsp_id), 64'h0);
    check("hrst_neg_a", 64'(neg_a), 64'h0);
    check("hrst_ready", 64'(req_ready), 64'h0);
    check("hrst_count", 64'(op_count), 64'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hrst_quiet", 64'(rsp_valid), 64'h0);
    end
    set_req(2, 64'h0, 1'b0);
    set_req(3, 64'h8000_0000_0000_0000, 1'b1);
    wait_grant(4'b0100);
    req_valid[2] = 1'b0;
    wait_rsp(2, 2'd2, 64'h0);
    wait_grant(4'b1000);
    req_valid[3] = 1'b0;
    wait_rsp(3, 2'd3, 64'h8000_0000_0000_0000);
    check("op_count_end", 64'(op_count), exp_count());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
